riscv_test_monitor: RTL and testbench

- Synthesizable successor to the simulation-only pass/fail checker around riscv_soc. Usable on FPGA and in simulation.
- Snoops the core's register write-back port and the jump bus.
- Detects the riscv-tests end signature and settles for a fixed time before sampling the verdict.
- Enforces a cycle timeout, counts taken jumps, and exposes a sticky status for LEDs, a UART or a bench.

---
 rtl/riscv_mon_pkg.sv | 18 +
 rtl/riscv_mon_trace_fifo.sv | 52 +++++
 rtl/riscv_test_monitor.sv | 187 ++++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mon_pkg.sv
// Shared types and constants for the riscv-tests pass/fail monitor.
package riscv_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_t;

  // riscv-tests convention: x26 = end flag, x27 = pass flag, x3 (gp) = test number
  localparam int unsigned DEF_DONE_REG = 26;
  localparam int unsigned DEF_PASS_REG = 27;
  localparam int unsigned DEF_TNUM_REG = 3;

  localparam int unsigned VERDICT_W = 32;

endpackage

// File: rtl/riscv_mon_trace_fifo.sv
// Jump trace FIFO: synchronous, first-word-fall-through, DEPTH a power of two.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module riscv_mon_trace_fifo
  import riscv_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv-tests end-signature monitor with settle delay, cycle timeout and jump count.
// Define RISCV_MON_TRACE_EN to add the jump trace FIFO and its trace_* ports.
//
// state  | meaning
// IDLE   | waiting for start after reset
// RUN    | test executing; cycle timeout armed
// SETTLE | end signature seen; waiting before sampling the verdict
// DONE   | verdict held until start or rst
module riscv_test_monitor
  import riscv_mon_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2500,
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned DONE_REG       = DEF_DONE_REG,
  parameter int unsigned PASS_REG       = DEF_PASS_REG,
  parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
  parameter int unsigned TRACE_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [VERDICT_W-1:0] wb_data,
  input  logic                 jump_valid,
  input  logic [ADDR_W-1:0]    jump_from,
  input  logic [ADDR_W-1:0]    jump_to,
`ifdef RISCV_MON_TRACE_EN
  input  logic                 trace_rd,
  output logic                 trace_valid,
  output logic [ADDR_W-1:0]    trace_from,
  output logic [ADDR_W-1:0]    trace_to,
  output logic                 trace_ovf,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [VERDICT_W-1:0] fail_testnum,
  output logic [TIMEOUT_W-1:0] cycle_cnt,
  output logic [15:0]          jump_cnt
);

  if (TIMEOUT_CYCLES < 1 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_W) ||
      SETTLE_CYCLES < 1 || TRACE_DEPTH < 2 ||
      (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_param_check
    $error("riscv_test_monitor: illegal parameter combination");
  end

  localparam logic [4:0] DONE_IDX = 5'(DONE_REG);
  localparam logic [4:0] PASS_IDX = 5'(PASS_REG);
  localparam logic [4:0] TNUM_IDX = 5'(TNUM_REG);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mon_state_t           state;
  mon_state_t           state_next;
  logic [SET_W-1:0]     settle_cnt;
  logic [VERDICT_W-1:0] pass_sh;
  logic [VERDICT_W-1:0] tnum_sh;
  logic [VERDICT_W-1:0] pass_src;
  logic                 wb_live;
  logic                 sig_end;
  logic                 active;
  logic                 jump_hit;
  logic                 arm;
  logic                 enter_settle;
  logic                 to_hit;
  logic                 verdict;

  assign wb_live  = wb_en && (wb_addr != 5'd0);
  assign sig_end  = wb_live && (wb_addr == DONE_IDX) && (wb_data == VERDICT_W'(1));
  // a pass-flag write in the last SETTLE cycle must reach the sample
  assign pass_src = (wb_live && (wb_addr == PASS_IDX)) ? wb_data : pass_sh;
  assign active   = (state == ST_RUN) || (state == ST_SETTLE);
  assign busy     = active;
  assign jump_hit = active && jump_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    arm          = 1'b0;
    enter_settle = 1'b0;
    to_hit       = 1'b0;
    verdict      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          arm        = 1'b1;
        end
      end
      ST_RUN: begin
        if (sig_end) begin
          state_next   = ST_SETTLE;
          enter_settle = 1'b1;
        end else if (cycle_cnt == TO_LAST) begin
          state_next = ST_DONE;
          to_hit     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = ST_DONE;
          verdict    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      cycle_cnt    <= '0;
      jump_cnt     <= '0;
      pass_sh      <= '0;
      tnum_sh      <= '0;
      settle_cnt   <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      if (wb_live && (state != ST_DONE)) begin
        if (wb_addr == PASS_IDX) pass_sh <= wb_data;
        if (wb_addr == TNUM_IDX) tnum_sh <= wb_data;
      end
      if ((state == ST_RUN) && (state_next == ST_RUN)) cycle_cnt <= cycle_cnt + 1'b1;
      if (jump_hit && (jump_cnt != 16'hFFFF)) jump_cnt <= jump_cnt + 1'b1;
      if (enter_settle)
        settle_cnt <= SET_LOAD;
      else if ((state == ST_SETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 1'b1;
      if (to_hit) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
      if (verdict) begin
        done         <= 1'b1;
        pass         <= (pass_src == VERDICT_W'(1));
        fail_testnum <= tnum_sh;
      end
    end
  end

`ifdef RISCV_MON_TRACE_EN
  logic                  trace_full;
  logic [2*ADDR_W-1:0]   trace_word;

  riscv_mon_trace_fifo #(
    .WIDTH (2 * ADDR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (arm),
    .push    (jump_hit),
    .pop     (trace_rd),
    .wr_data ({jump_from, jump_to}),
    .rd_data (trace_word),
    .valid   (trace_valid),
    .full    (trace_full)
  );

  assign trace_from = trace_word[2*ADDR_W-1:ADDR_W];
  assign trace_to   = trace_word[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || arm)
      trace_ovf <= 1'b0;
    else if (jump_hit && trace_full && !(trace_rd && trace_valid))
      trace_ovf <= 1'b1;
  end
`else
  logic unused_jump;
  assign unused_jump = ^{jump_from, jump_to};
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: each verdict's expected values are queued
// by the stimulus and compared by a monitor when done rises.
module tb_riscv_test_monitor;

  localparam int SETTLE = 3;
  localparam int TO_A   = 16;
  localparam int TO_B   = 100000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, wb_en, jump_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, jump_from, jump_to;
  logic        busy, done, pass, timeout;
  logic [31:0] fail_testnum;
  logic [23:0] cycle_cnt;
  logic [15:0] jump_cnt;

  logic        start_b, jump_valid_b, wb_en_b;
  logic [4:0]  wb_addr_b;
  logic [31:0] wb_data_b;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [31:0] fail_testnum_b;
  logic [23:0] cycle_cnt_b;
  logic [15:0] jump_cnt_b;

`ifdef RISCV_MON_TRACE_EN
  logic        trace_rd, trace_valid, trace_ovf;
  logic [31:0] trace_from, trace_to;
  logic        trace_rd_b, trace_valid_b, trace_ovf_b;
  logic [31:0] trace_from_b, trace_to_b;
`endif

  riscv_test_monitor #(.TIMEOUT_CYCLES(TO_A), .SETTLE_CYCLES(SETTLE), .TRACE_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump_valid(jump_valid), .jump_from(jump_from), .jump_to(jump_to),
`ifdef RISCV_MON_TRACE_EN
    .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_from(trace_from),
    .trace_to(trace_to), .trace_ovf(trace_ovf),
`endif
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .fail_testnum(fail_testnum),
    .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt));

  riscv_test_monitor #(.TIMEOUT_CYCLES(TO_B), .SETTLE_CYCLES(SETTLE)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wb_en(wb_en_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
    .jump_valid(jump_valid_b), .jump_from(32'h0), .jump_to(32'h0),
`ifdef RISCV_MON_TRACE_EN
    .trace_rd(trace_rd_b), .trace_valid(trace_valid_b), .trace_from(trace_from_b),
    .trace_to(trace_to_b), .trace_ovf(trace_ovf_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .fail_testnum(fail_testnum_b),
    .cycle_cnt(cycle_cnt_b), .jump_cnt(jump_cnt_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [31:0] tnum;
    logic [23:0] cnt;
    logic [15:0] jmp;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic done_q = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no verdict (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("pass", {63'd0, pass}, {63'd0, e.pass});
        chk("timeout", {63'd0, timeout}, {63'd0, e.timeout});
        chk("fail_testnum", {32'd0, fail_testnum}, {32'd0, e.tnum});
        chk("cycle_cnt", {40'd0, cycle_cnt}, {40'd0, e.cnt});
        chk("jump_cnt", {48'd0, jump_cnt}, {48'd0, e.jmp});
      end
    end
    done_q <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic arm(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic push_exp(input logic p, input logic to, input logic [31:0] tn,
                          input logic [23:0] cn, input logic [15:0] jm, input int at);
    exp_t e;
    e.pass = p; e.timeout = to; e.tnum = tn; e.cnt = cn; e.jmp = jm; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: got done=%b expected done=1 within %0d cycles", name, done, limit);
    end
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
    chk({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
    chk({tag, "_tnum"}, {32'd0, fail_testnum}, 64'd0);
    chk({tag, "_cycle_cnt"}, {40'd0, cycle_cnt}, 64'd0);
    chk({tag, "_jump_cnt"}, {48'd0, jump_cnt}, 64'd0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got no end of test expected finish before 1.5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s, t;
    logic [31:0] ef, et;
    rst = 1'b1; start = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    jump_valid = 1'b0; jump_from = 32'd0; jump_to = 32'd0;
    start_b = 1'b0; jump_valid_b = 1'b0; wb_en_b = 1'b0; wb_addr_b = 5'd0; wb_data_b = 32'd0;
`ifdef RISCV_MON_TRACE_EN
    trace_rd = 1'b0; trace_rd_b = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk_all_zero("reset");
    chk("reset_b_jump_cnt", {48'd0, jump_cnt_b}, 64'd0);

    // pass: x27=1, three jumps, x26=1 at RUN cycle 10
    arm(s);
    chk("start_busy", {63'd0, busy}, 64'd1);
    wb(5'd27, 32'd1);
    jump_valid = 1'b1;
    repeat (3) tick();
    jump_valid = 1'b0;
    repeat (6) tick();
    t = cyc;
    push_exp(1'b1, 1'b0, 32'd0, 24'd10, 16'd3, t + SETTLE + 1);
    wb(5'd26, 32'd1);
    wait_done("pass_done", 10);

    // fail: x3=5, x27=0, x26=1 at RUN cycle 2; re-armed from DONE
    arm(s);
    chk("rearm_done", {63'd0, done}, 64'd0);
    chk("rearm_pass", {63'd0, pass}, 64'd0);
    chk("rearm_jump_cnt", {48'd0, jump_cnt}, 64'd0);
    wb(5'd3, 32'd5);
    wb(5'd27, 32'd0);
    t = cyc;
    push_exp(1'b0, 1'b0, 32'd5, 24'd2, 16'd0, t + SETTLE + 1);
    wb(5'd26, 32'd1);
    wait_done("fail_done", 10);

    // timeout, then DONE ignores further signatures and jumps
    arm(s);
    push_exp(1'b0, 1'b1, 32'd0, 24'(TO_A - 1), 16'd0, s + TO_A);
    wait_done("timeout_done", 30);
    wb(5'd26, 32'd1);
    jump_valid = 1'b1;
    tick();
    jump_valid = 1'b0;
    repeat (6) tick();
    chk("hold_done", {63'd0, done}, 64'd1);
    chk("hold_timeout", {63'd0, timeout}, 64'd1);
    chk("hold_pass", {63'd0, pass}, 64'd0);
    chk("hold_cycle_cnt", {40'd0, cycle_cnt}, 64'(TO_A - 1));
    chk("hold_jump_cnt", {48'd0, jump_cnt}, 64'd0);
    chk("hold_busy", {63'd0, busy}, 64'd0);

    // race at cnt==15, x0 write ignored, start in SETTLE ignored, late x27 bypass
    arm(s);
    wb(5'd0, 32'd1);
    repeat (14) tick();
    t = cyc;
    push_exp(1'b1, 1'b0, 32'd0, 24'(TO_A - 1), 16'd0, t + SETTLE + 1);
    wb(5'd26, 32'd1);
    chk("settle_busy", {63'd0, busy}, 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wb(5'd27, 32'd1);
    wait_done("race_done", 10);

    // reset mid-RUN
    arm(s);
    jump_valid = 1'b1;
    repeat (4) tick();
    jump_valid = 1'b0;
    chk("midrun_cycle_cnt", {40'd0, cycle_cnt}, 64'd4);
    chk("midrun_jump_cnt", {48'd0, jump_cnt}, 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrun_rst");

`ifdef RISCV_MON_TRACE_EN
    // nine jumps, no reads: eight kept in order, overflow flagged
    arm(s);
    push_exp(1'b0, 1'b1, 32'd0, 24'(TO_A - 1), 16'd9, s + TO_A);
    chk("trace_ovf_init", {63'd0, trace_ovf}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      jump_valid = 1'b1;
      jump_from = 32'h1000 + 32'(i * 4);
      jump_to = 32'h2000 + 32'(i * 16);
      tick();
    end
    jump_valid = 1'b0;
    chk("trace_ovf_set", {63'd0, trace_ovf}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      ef = 32'h1000 + 32'(i * 4);
      et = 32'h2000 + 32'(i * 16);
      chk("trace_valid", {63'd0, trace_valid}, 64'd1);
      chk("trace_from", {32'd0, trace_from}, {32'd0, ef});
      chk("trace_to", {32'd0, trace_to}, {32'd0, et});
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    chk("trace_empty", {63'd0, trace_valid}, 64'd0);
    wait_done("trace1_done", 30);

    // full FIFO: push with simultaneous read is accepted, no overflow
    arm(s);
    push_exp(1'b0, 1'b1, 32'd0, 24'(TO_A - 1), 16'd9, s + TO_A);
    chk("trace_ovf_cleared", {63'd0, trace_ovf}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      jump_valid = 1'b1;
      jump_from = 32'h1000 + 32'(i * 4);
      jump_to = 32'h2000 + 32'(i * 16);
      trace_rd = (i == 8);
      tick();
    end
    jump_valid = 1'b0;
    trace_rd = 1'b0;
    chk("trace_ovf_pushpop", {63'd0, trace_ovf}, 64'd0);
    chk("trace_head_from", {32'd0, trace_from}, 64'h1004);
    chk("trace_head_to", {32'd0, trace_to}, 64'h2010);
    wait_done("trace2_done", 30);
`endif

    // jump counter saturation on the long-timeout instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    jump_valid_b = 1'b1;
    repeat (65534) tick();
    chk("sat_jump_cnt_fffe", {48'd0, jump_cnt_b}, 64'hFFFE);
    tick();
    chk("sat_jump_cnt_ffff", {48'd0, jump_cnt_b}, 64'hFFFF);
    repeat (70000 - 65535) tick();
    jump_valid_b = 1'b0;
    chk("sat_jump_cnt_hold", {48'd0, jump_cnt_b}, 64'hFFFF);
    chk("sat_cycle_cnt", {40'd0, cycle_cnt_b}, 64'd70000);
    chk("sat_busy", {63'd0, busy_b}, 64'd1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
